// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
//   rx_state_e           : receiver FSM state encoding (also exported for debug)
//   PAR_NONE/EVEN/ODD    : PARITY_MODE encodings
//   DEFAULT_N_OVERSAMPLE : default number of i_tick pulses per bit
//   majority3()          : 2-of-3 vote used by the bit sampler
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_RECOVER = 3'd5
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEFAULT_N_OVERSAMPLE = 16;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver: 2-flop synchronizer on the raw
// serial line plus a 3-sample majority voter.
//   i_clock   : system clock
//   i_reset   : asynchronous active-low reset (flops reset to line-idle 1)
//   i_rx      : raw asynchronous serial line
//   i_sample  : store the current synchronized value as a vote sample
//   o_rx_sync : synchronized line value (2 i_clock latency)
//   o_vote    : majority of the two stored samples and the current value,
//               so the vote is ready on the cycle of the third sample
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_rx,
  input  logic i_sample,
  output logic o_rx_sync,
  output logic o_vote
);

  logic       meta_q;
  logic       sync_q;
  logic [1:0] samp_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      samp_q <= 2'b11;
    end else begin
      meta_q <= i_rx;
      sync_q <= meta_q;
      if (i_sample) begin
        samp_q <= {samp_q[0], sync_q};
      end
    end
  end

  assign o_rx_sync = sync_q;
  assign o_vote    = majority3(samp_q[1], samp_q[0], sync_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver.
//   Parameters : NB_DATA (5..9), N_OVERSAMPLE (even, >= 8), N_STOP (1..2),
//                PARITY_MODE (PAR_NONE / PAR_EVEN / PAR_ODD)
//   i_clock        : system clock
//   i_reset        : asynchronous active-low reset
//   i_tick         : one-cycle oversampling enable
//   i_rx           : serial line, idle high
//   o_data         : last received word, LSB = first data bit
//   o_rx_done_tick : one-cycle pulse when a frame completes
//   o_parity_err   : parity mismatch of the completed frame
//   o_frame_err    : a stop bit was sampled low
//   o_break        : data, parity and first stop bit all sampled low
//   o_state        : current FSM state (debug)
// Each bit spans N_OVERSAMPLE ticks, indexed 0..N-1 by tick_cnt_q. Votes are
// taken at ticks N/2-1, N/2, N/2+1; the bit value is acted on at N/2+1.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int NB_DATA      = 8,
  parameter int N_OVERSAMPLE = DEFAULT_N_OVERSAMPLE,
  parameter int N_STOP       = 1,
  parameter int PARITY_MODE  = PAR_NONE
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done_tick,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_break,
  output rx_state_e          o_state
);

  localparam int TICK_W = $clog2(N_OVERSAMPLE);
  localparam int BIT_W  = $clog2(NB_DATA + 1);
  localparam int MID    = N_OVERSAMPLE / 2;

  localparam logic [TICK_W-1:0] T_S0   = TICK_W'(MID - 1);
  localparam logic [TICK_W-1:0] T_S1   = TICK_W'(MID);
  localparam logic [TICK_W-1:0] T_EVAL = TICK_W'(MID + 1);
  localparam logic [TICK_W-1:0] T_LAST = TICK_W'(N_OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  B_LAST_DATA = BIT_W'(NB_DATA - 1);
  localparam logic [BIT_W-1:0]  B_LAST_STOP = BIT_W'(N_STOP - 1);

  rx_state_e          state_q, state_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic               par_acc_q, par_acc_d;     // XOR of data and parity votes
  logic               low_acc_q, low_acc_d;     // every vote so far was low
  logic               frame_acc_q, frame_acc_d; // an earlier stop bit was low
  logic [NB_DATA-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic               brk_q, brk_d;

  logic rx_sync;
  logic vote;
  logic in_frame;
  logic tick_last;
  logic at_eval;
  logic sample_en;
  logic par_err;
  logic stop_ferr;
  logic stop_low;

  uart_rx_sync u_sync (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_rx      (i_rx),
    .i_sample  (sample_en),
    .o_rx_sync (rx_sync),
    .o_vote    (vote)
  );

  assign in_frame  = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign tick_last = (tick_cnt_q == T_LAST);
  assign at_eval   = i_tick && (tick_cnt_q == T_EVAL);
  assign sample_en = i_tick && in_frame &&
                     ((tick_cnt_q == T_S0) || (tick_cnt_q == T_S1));

  assign par_err   = (PARITY_MODE == PAR_EVEN) ? par_acc_q :
                     (PARITY_MODE == PAR_ODD)  ? ~par_acc_q : 1'b0;
  assign stop_ferr = frame_acc_q | ~vote;
  // Only the first stop bit takes part in break detection.
  assign stop_low  = (bit_cnt_q == '0) ? (low_acc_q & ~vote) : low_acc_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_acc_q   <= 1'b0;
      low_acc_q   <= 1'b0;
      frame_acc_q <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_acc_q   <= par_acc_d;
      low_acc_q   <= low_acc_d;
      frame_acc_q <= frame_acc_d;
      data_q      <= data_d;
      done_q      <= done_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      brk_q       <= brk_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_acc_d   = par_acc_q;
    low_acc_d   = low_acc_q;
    frame_acc_d = frame_acc_q;
    data_d      = data_q;
    done_d      = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    brk_d       = brk_q;

    // Free-running bit timing inside a frame; state-specific branches below
    // override it where a state exits early.
    if (i_tick && in_frame) begin
      tick_cnt_d = tick_last ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_tick && !rx_sync) begin
          state_d     = ST_START;
          tick_cnt_d  = '0;
          bit_cnt_d   = '0;
          shift_d     = '0;
          par_acc_d   = 1'b0;
          low_acc_d   = 1'b1;
          frame_acc_d = 1'b0;
        end
      end

      ST_START: begin
        if (at_eval && vote) begin
          // Start bit did not hold low through its centre: treat as a glitch.
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
        end else if (i_tick && tick_last) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (at_eval) begin
          shift_d   = {vote, shift_q[NB_DATA-1:1]};
          par_acc_d = par_acc_q ^ vote;
          low_acc_d = low_acc_q & ~vote;
        end
        if (i_tick && tick_last) begin
          if (bit_cnt_q == B_LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (at_eval) begin
          par_acc_d = par_acc_q ^ vote;
          low_acc_d = low_acc_q & ~vote;
        end
        if (i_tick && tick_last) begin
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (at_eval) begin
          if (bit_cnt_q == B_LAST_STOP) begin
            // Final stop bit: report now instead of waiting out the bit so
            // a following start edge can be caught with zero idle gap.
            done_d     = 1'b1;
            data_d     = shift_q;
            perr_d     = par_err;
            ferr_d     = stop_ferr;
            brk_d      = stop_low;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = stop_ferr ? ST_RECOVER : ST_IDLE;
          end else begin
            frame_acc_d = stop_ferr;
            low_acc_d   = stop_low;
          end
        end else if (i_tick && tick_last) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      ST_RECOVER: begin
        // Hold off until the line is released so a break cannot re-trigger.
        if (i_tick && rx_sync) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_data         = data_q;
  assign o_rx_done_tick = done_q;
  assign o_parity_err   = perr_q;
  assign o_frame_err    = ferr_q;
  assign o_break        = brk_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) share clock, tick
// and reset; one serial driver is steered to the selected instance while the
// others idle high. Every frame sent pushes its expected result, computed
// from the transmitted bit values, onto that instance's expected queue.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int NB = 8;
  localparam int OS = 16;
  localparam int W  = NB + 3;   // {break, frame_err, parity_err, data}

  // ---------------- clock / tick / reset ----------------
  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic tick     = 1'b0;
  logic rx_drive = 1'b1;
  int   sel      = 0;

  always #5 clk = ~clk;

  // One-cycle tick every fourth clock.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  logic rx_n1, rx_e1, rx_n2;
  assign rx_n1 = (sel == 0) ? rx_drive : 1'b1;
  assign rx_e1 = (sel == 1) ? rx_drive : 1'b1;
  assign rx_n2 = (sel == 2) ? rx_drive : 1'b1;

  logic [NB-1:0] data_n1, data_e1, data_n2;
  logic done_n1, done_e1, done_n2;
  logic perr_n1, perr_e1, perr_n2;
  logic ferr_n1, ferr_e1, ferr_n2;
  logic brk_n1, brk_e1, brk_n2;
  rx_state_e state_n1, state_e1, state_n2;

  uart_rx_cfg #(.NB_DATA(NB), .N_OVERSAMPLE(OS), .N_STOP(1), .PARITY_MODE(PAR_NONE)) dut_n1 (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_rx(rx_n1),
    .o_data(data_n1), .o_rx_done_tick(done_n1), .o_parity_err(perr_n1),
    .o_frame_err(ferr_n1), .o_break(brk_n1), .o_state(state_n1));

  uart_rx_cfg #(.NB_DATA(NB), .N_OVERSAMPLE(OS), .N_STOP(1), .PARITY_MODE(PAR_EVEN)) dut_e1 (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_rx(rx_e1),
    .o_data(data_e1), .o_rx_done_tick(done_e1), .o_parity_err(perr_e1),
    .o_frame_err(ferr_e1), .o_break(brk_e1), .o_state(state_e1));

  uart_rx_cfg #(.NB_DATA(NB), .N_OVERSAMPLE(OS), .N_STOP(2), .PARITY_MODE(PAR_NONE)) dut_n2 (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_rx(rx_n2),
    .o_data(data_n2), .o_rx_done_tick(done_n2), .o_parity_err(perr_n2),
    .o_frame_err(ferr_n2), .o_break(brk_n2), .o_state(state_n2));

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q_n1[$];
  logic [W-1:0]  exp_q_e1[$];
  logic [W-1:0]  exp_q_n2[$];
  logic [NB-1:0] last_data [3];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame result from the transmitted bits. which: 0 = 8N1, 1 = 8E1, 2 = 8N2.
  function automatic logic [W-1:0] model(input int which, input logic [NB-1:0] d,
                                         input logic pbit, input logic [1:0] stops);
    int   ones;
    logic perr, ferr, brk;
    ones = $countones(d) + ((which == 1) ? int'(pbit) : 0);
    perr = (which == 1) && (ones % 2 == 1);
    ferr = !stops[0] || ((which == 2) && !stops[1]);
    brk  = (d == '0) && ((which != 1) || !pbit) && !stops[0];
    return {brk, ferr, perr, d};
  endfunction

  always @(negedge clk) begin
    if (done_n1) begin
      if (exp_q_n1.size() == 0) check("n1_unexpected_done", 1, 0);
      else check("n1_frame", {brk_n1, ferr_n1, perr_n1, data_n1}, exp_q_n1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (done_e1) begin
      if (exp_q_e1.size() == 0) check("e1_unexpected_done", 1, 0);
      else check("e1_frame", {brk_e1, ferr_e1, perr_e1, data_e1}, exp_q_e1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (done_n2) begin
      if (exp_q_n2.size() == 0) check("n2_unexpected_done", 1, 0);
      else check("n2_frame", {brk_n2, ferr_n2, perr_n2, data_n2}, exp_q_n2.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end on a tick edge; the line changes 1 unit later.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) @(posedge clk iff tick);
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      #1 rx_drive = 1'b1;
      wait_ticks(n);
    end
  endtask

  // spike: flip the line for exactly the tick the receiver uses as its
  // centre vote sample of this bit.
  task automatic send_bit(input logic v, input logic spike);
    #1 rx_drive = v;
    if (spike) begin
      wait_ticks(9);
      #1 rx_drive = ~v;
      wait_ticks(1);
      #1 rx_drive = v;
      wait_ticks(OS - 10);
    end else begin
      wait_ticks(OS);
    end
  endtask

  task automatic push_exp(input int which, input logic [W-1:0] e);
    case (which)
      0:       exp_q_n1.push_back(e);
      1:       exp_q_e1.push_back(e);
      default: exp_q_n2.push_back(e);
    endcase
    last_data[which] = e[NB-1:0];
  endtask

  task automatic send_frame(input int which, input logic [NB-1:0] d, input logic pbit,
                            input logic [1:0] stops, input logic spike);
    sel = which;
    push_exp(which, model(which, d, pbit, stops));
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < NB; i++) send_bit(d[i], spike);
    if (which == 1) send_bit(pbit, 1'b0);
    send_bit(stops[0], 1'b0);
    if (which == 2) send_bit(stops[1], 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [NB-1:0] d;
    logic          pbit;
    logic [1:0]    stops;
    int            which;
    int            gap;

    for (int i = 0; i < 3; i++) last_data[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("n1_reset_out", {data_n1, done_n1, perr_n1, ferr_n1, brk_n1}, 0);
    check("e1_reset_out", {data_e1, done_e1, perr_e1, ferr_e1, brk_e1}, 0);
    check("n2_reset_out", {data_n2, done_n2, perr_n2, ferr_n2, brk_n2}, 0);
    check("n1_reset_state", state_n1, ST_IDLE);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ticks(3);

    // 8N1 basic frame
    send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b0);
    idle(4);
    @(negedge clk);
    check("n1_hold_a5", {brk_n1, ferr_n1, perr_n1, data_n1}, {3'b000, 8'hA5});
    wait_ticks(1);

    // 8E1 parity error, then correct parity
    send_frame(1, 8'h07, 1'b0, 2'b11, 1'b0);
    send_frame(1, 8'h07, 1'b1, 2'b11, 1'b0);
    idle(4);

    // Glitch rejection on idle line, then a good frame
    sel = 0;
    #1 rx_drive = 1'b0;
    wait_ticks(4);
    #1 rx_drive = 1'b1;
    wait_ticks(24);
    @(negedge clk);
    check("n1_glitch_state", state_n1, ST_IDLE);
    check("n1_glitch_nodone", exp_q_n1.size(), 0);
    wait_ticks(1);
    send_frame(0, 8'h3C, 1'b0, 2'b11, 1'b0);
    idle(4);

    // 8N2 second stop bit low
    send_frame(2, 8'h5A, 1'b0, 2'b01, 1'b0);
    idle(4);

    // 8N2 break: 20 bit times low
    sel = 2;
    push_exp(2, model(2, 8'h00, 1'b0, 2'b00));
    #1 rx_drive = 1'b0;
    wait_ticks(20 * OS);
    @(negedge clk);
    check("n2_break_state", state_n2, ST_RECOVER);
    check("n2_break_pending", exp_q_n2.size(), 0);
    wait_ticks(1);
    idle(4);
    @(negedge clk);
    check("n2_after_break_state", state_n2, ST_IDLE);
    check("n2_break_hold", {brk_n2, ferr_n2, perr_n2, data_n2}, {3'b110, 8'h00});
    wait_ticks(1);
    send_frame(2, 8'hC3, 1'b0, 2'b11, 1'b0);
    idle(2);

    // Majority vote rejects single-tick spikes at each data bit centre
    send_frame(0, 8'hF0, 1'b0, 2'b11, 1'b1);

    // Back-to-back frames, the second aborted by reset
    send_frame(0, 8'h55, 1'b0, 2'b11, 1'b0);
    send_bit(1'b0, 1'b0);           // start of 0xAA
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    #1 rx_drive = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("n1_midreset_out", {data_n1, done_n1, perr_n1, ferr_n1, brk_n1}, 0);
    check("n1_midreset_state", state_n1, ST_IDLE);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) last_data[i] = '0;
    wait_ticks(2 * 11 * OS);
    @(negedge clk);
    check("n1_after_reset_out", {data_n1, perr_n1, ferr_n1, brk_n1}, 0);
    check("n1_after_reset_state", state_n1, ST_IDLE);
    check("n1_abort_nodone", exp_q_n1.size(), 0);
    wait_ticks(1);
    send_frame(0, 8'h96, 1'b0, 2'b11, 1'b0);

    // Randomized frames across all three configurations
    for (int n = 0; n < 24; n++) begin
      which    = $urandom_range(0, 2);
      d        = ($urandom_range(0, 5) == 0) ? '0 : NB'($urandom_range(0, 255));
      pbit     = (^d) ^ ($urandom_range(0, 3) == 0);
      stops[0] = ($urandom_range(0, 4) != 0);
      stops[1] = ($urandom_range(0, 4) != 0);
      gap      = (!stops[0] || !stops[1]) ? $urandom_range(3, 8) : $urandom_range(0, 6);
      send_frame(which, d, pbit, stops, 1'b0);
      idle(gap);
    end
    idle(4);

    // Final scoreboard and hold checks
    @(negedge clk);
    check("n1_queue_empty", exp_q_n1.size(), 0);
    check("e1_queue_empty", exp_q_e1.size(), 0);
    check("n2_queue_empty", exp_q_n2.size(), 0);
    check("n1_hold_last", data_n1, last_data[0]);
    check("e1_hold_last", data_e1, last_data[1]);
    check("n2_hold_last", data_n2, last_data[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter NB_DATA, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter N_OVERSAMPLE, default 16, i_tick pulses per bit; SHALL be even and at least 8.
REQ-003 Parameter N_STOP, default 1, stop bits checked; legal 1 or 2.
REQ-004 Parameter PARITY_MODE, default 0, 0 none / 1 even / 2 odd.
REQ-005 i_clock  in  1  single system clock; all logic on its rising edge.
REQ-006 i_reset  in  1  reset, asynchronous, active-low.
REQ-007 i_tick  in  1  oversampling enable from baud generator, one i_clock wide.
REQ-008 i_rx  in  1  asynchronous serial line, idle high.
REQ-009 o_data  out  NB_DATA  last received word, LSB = first data bit.
REQ-010 o_rx_done_tick  out  1  one-i_clock pulse when a frame completes.
REQ-011 o_parity_err  out  1  parity mismatch of the completed frame, valid with o_rx_done_tick.
REQ-012 o_frame_err  out  1  a stop bit sampled low, valid with o_rx_done_tick.
REQ-013 o_break  out  1  all data bits, parity (if any) and first stop bit sampled low, valid with o_rx_done_tick.

Function
REQ-014 i_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2 i_clock latency).
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP, RECOVER; counters advance only on i_tick cycles.
REQ-016 IDLE: a synchronized low on an i_tick cycle -> START with tick counter cleared.
REQ-017 Each bit is sampled by majority vote of 3 samples taken at ticks N_OVERSAMPLE/2-1, N_OVERSAMPLE/2, N_OVERSAMPLE/2+1 of that bit.
REQ-018 START: voted start bit high -> IDLE with no outputs asserted (glitch rejection); low -> DATA after the bit's N_OVERSAMPLE ticks.
REQ-019 DATA: shift NB_DATA voted bits LSB-first; after the last -> PARITY if PARITY_MODE != 0, else STOP.
REQ-020 PARITY: error when XOR of data bits and parity bit is 1 (even) or 0 (odd); PARITY_MODE 0 forces o_parity_err to 0.
REQ-021 STOP: check N_STOP stop bits; any voted low sets the frame error.
REQ-022 The FSM SHALL not wait the remainder of the final stop bit; it evaluates at the final stop bit's third vote sample.
REQ-023 o_rx_done_tick SHALL pulse 1 i_clock after that third vote sample, with o_data and the error flags updated in the same cycle.
REQ-024 o_data and the error flags SHALL hold until the next o_rx_done_tick.
REQ-025 No frame error -> IDLE; frame error -> RECOVER, which waits for synchronized i_rx high on an i_tick cycle before IDLE (no re-trigger during break).
REQ-026 A new start edge arriving in IDLE immediately after REQ-023 SHALL be accepted (back-to-back frames, zero idle gap).
REQ-027 i_tick high in the same cycle as a state transition counts toward the new state; counter widths SHALL be $clog2(N_OVERSAMPLE) and $clog2(NB_DATA+1).

Reset
REQ-028 Reset SHALL force: state IDLE, counters 0, shift register 0, synchronizer flops 1, o_data 0, all flags and o_rx_done_tick 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no o_rx_done_tick; after release the FSM resumes from IDLE and waits for the next falling edge.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state encoding, the PARITY_MODE encodings (PAR_NONE, PAR_EVEN, PAR_ODD) and the default N_OVERSAMPLE.
REQ-031 One sub-module, uart_rx_sync: 2-flop synchronizer plus 3-sample majority voter.

Verification
REQ-032 8N1, N_OVERSAMPLE 16, byte 0xA5 -> o_data 0xA5, one done pulse, all flags 0.
REQ-033 8E1, byte 0x07 with parity bit driven 0 -> o_parity_err 1, o_data 0x07; repeat with parity bit 1 -> o_parity_err 0.
REQ-034 Low glitch of 4 ticks on idle line -> no done pulse, FSM back in IDLE; next frame 0x3C received correctly.
REQ-035 8N2, second stop bit driven low -> o_frame_err 1; 20-bit-time line-low break -> o_break 1, o_frame_err 1, o_data 0x00, and no further frame until the line returns high.
REQ-036 Two back-to-back frames 0x55 then 0xAA with zero idle gap -> two done pulses, correct data; reset pulsed mid-frame during the second frame -> only 0x55 reported, outputs 0 after reset.
REQ-037 Single-tick-wide spike of the opposite value at the centre sample of each data bit of 0xF0 -> majority vote still yields 0xF0.
